// File: rtl/image_uart_sender_pkg.sv
// Shared sequencer state encoding and frame geometry for the image UART sender.
package image_uart_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_FIN
  } state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/image_uart_sender_uart_byte_tx.sv
// 8N1 byte serializer; ready marks the last stop-bit cycle so the next byte
// can be loaded with no idle gap.
module uart_byte_tx #(
  parameter int unsigned SERIAL_WCNT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [8:0]  shreg;
  logic        active;

  assign ready = active && (bit_idx == 4'd9) && (cnt == 16'(SERIAL_WCNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd     <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '1;
      active  <= 1'b0;
    end else if (load && (!active || ready)) begin
      txd     <= 1'b0;
      shreg   <= {1'b1, data};
      cnt     <= '0;
      bit_idx <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (cnt == 16'(SERIAL_WCNT - 1)) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          // shifting in ones makes the stop bit fall out after the data bits
          txd     <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/image_uart_sender.sv
// Streams a length header followed by num_words memory words over a UART line,
// prefetching each word during the last byte of the previous group.
module image_uart_sender
  import image_uart_sender_pkg::*;
#(
  parameter int unsigned SERIAL_WCNT = 100,
  parameter int unsigned ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              start,
  input  logic [31:0]       num_words,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe,
  input  logic [31:0]       mem_rdata,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  logic        rst_meta, rst_int;
  state_t      state;
  logic [29:0] num_q, word_cnt, fetch_idx;
  logic [1:0]  byte_cnt, next_idx;
  logic [31:0] word_q, hdr;
  logic        first, rd_pend;
  logic        ready, load, in_frame, last_in_group, final_byte;
  logic [7:0]  tx_data;
  logic        unused_bits;

  assign unused_bits = ^num_words[31:30];

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rst_meta <= 1'b1;
      rst_int  <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_int  <= rst_meta;
    end
  end

  // Every load after the first happens in the ready cycle and sends the byte
  // after byte_cnt; at a group boundary that is byte 0 of the prefetched word.
  always_comb begin
    hdr           = {num_q, 2'b00};
    next_idx      = byte_cnt + 2'd1;
    in_frame      = (state == ST_HDR) || (state == ST_DATA);
    last_in_group = (state == ST_HDR) ? (byte_cnt == 2'(HDR_BYTES - 1))
                                      : (byte_cnt == 2'(WORD_BYTES - 1));
    final_byte    = last_in_group && ((state == ST_HDR) ? (num_q == '0)
                                                        : (word_cnt == num_q - 30'd1));
    load          = first || (ready && in_frame && !final_byte);
    if (first)
      tx_data = hdr[7:0];
    else if ((state == ST_HDR) && !last_in_group)
      tx_data = hdr[{next_idx, 3'b000} +: 8];
    else
      tx_data = word_q[{next_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_oe    <= 1'b0;
      mem_addr  <= '0;
      num_q     <= '0;
      word_cnt  <= '0;
      fetch_idx <= '0;
      byte_cnt  <= '0;
      word_q    <= '0;
      first     <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      first   <= 1'b0;
      mem_oe  <= 1'b0;
      done    <= 1'b0;
      rd_pend <= mem_oe;
      if (rd_pend) word_q <= mem_rdata;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_HDR;
            busy      <= 1'b1;
            first     <= 1'b1;
            num_q     <= num_words[29:0];
            byte_cnt  <= '0;
            word_cnt  <= '0;
            fetch_idx <= '0;
          end
        end
        ST_HDR, ST_DATA: begin
          if (ready) begin
            if ((byte_cnt == 2'd2) && (fetch_idx != num_q)) begin
              mem_oe    <= 1'b1;
              mem_addr  <= fetch_idx[ADDR_W-1:0];
              fetch_idx <= fetch_idx + 30'd1;
            end
            byte_cnt <= next_idx;
            if (final_byte) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (last_in_group) begin
              if (state == ST_DATA) word_cnt <= word_cnt + 30'd1;
              state <= ST_DATA;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .SERIAL_WCNT(SERIAL_WCNT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst_int),
    .load  (load),
    .data  (tx_data),
    .ready (ready),
    .txd   (txd)
  );

endmodule

// File: tb/tb_image_uart_sender.sv
// Bench for image_uart_sender: two instances (wide/slow and narrow/fast) checked
// cycle by cycle against the expected serial waveform of the whole frame.
module tb_image_uart_sender;

  logic        clk = 1'b0;
  logic        rst_async, start_a, start_b;
  logic [31:0] num_words;
  logic [13:0] addr_a;
  logic [1:0]  addr_b;
  logic        oe_a, oe_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] mem [64];
  logic        sel;
  logic        txd_s, busy_s, done_s, oe_s;
  logic [31:0] addr_s;
  logic [31:0] addr_q [$];
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  image_uart_sender #(.SERIAL_WCNT(4), .ADDR_W(14)) dut_a (
    .clk(clk), .rst_async(rst_async), .start(start_a), .num_words(num_words),
    .mem_addr(addr_a), .mem_oe(oe_a), .mem_rdata(rdata_a),
    .txd(txd_a), .busy(busy_a), .done(done_a)
  );

  image_uart_sender #(.SERIAL_WCNT(2), .ADDR_W(2)) dut_b (
    .clk(clk), .rst_async(rst_async), .start(start_b), .num_words(num_words),
    .mem_addr(addr_b), .mem_oe(oe_b), .mem_rdata(rdata_b),
    .txd(txd_b), .busy(busy_b), .done(done_b)
  );

  // Read data is only meaningful the cycle after a strobe; otherwise it is noise.
  always @(posedge clk) begin
    rdata_a <= oe_a ? mem[addr_a[5:0]] : $urandom;
    rdata_b <= oe_b ? mem[{4'd0, addr_b}] : $urandom;
  end

  assign txd_s  = sel ? txd_b  : txd_a;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign oe_s   = sel ? oe_b   : oe_a;
  assign addr_s = sel ? {30'd0, addr_b} : {18'd0, addr_a};

  always @(negedge clk) if (oe_s) addr_q.push_back(addr_s);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int k, input int n, input int aw);
    logic [31:0] hdr, w;
    int idx;
    hdr = 32'(n) << 2;
    if (k < 4) return hdr[8*k +: 8];
    idx = ((k - 4) / 4) % (1 << aw);
    w = mem[idx[5:0]];
    return w[8*((k - 4) % 4) +: 8];
  endfunction

  function automatic logic exp_bit(input int i, input int n, input int w, input int aw);
    int k, pos;
    logic [7:0] b;
    k   = i / (10 * w);
    pos = (i / w) % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    b = frame_byte(k, n, aw);
    return b[pos - 1];
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge
  // of the cycle after done (or after an aborting reset has been released).
  task automatic run_frame(input int n, input int w, input int aw,
                           input int mid_start, input int abort_at);
    int total;
    total = (4 + 4 * n) * 10 * w;
    addr_q.delete();
    check("idle_busy", 32'(busy_s), 32'd0);
    num_words = {2'($urandom), 30'(n)};
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    num_words = $urandom;
    check("accept_busy", 32'(busy_s), 32'd1);
    check("accept_txd", 32'(txd_s), 32'd1);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_async = 1'b1;
        #1;
        check("rst_txd", 32'(txd_s), 32'd1);
        check("rst_busy", 32'(busy_s), 32'd0);
        check("rst_done", 32'(done_s), 32'd0);
        check("rst_oe", 32'(oe_s), 32'd0);
        repeat (2) @(negedge clk);
        rst_async = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check("post_rst_done", 32'(done_s), 32'd0);
          check("post_rst_busy", 32'(busy_s), 32'd0);
          check("post_rst_txd", 32'(txd_s), 32'd1);
        end
        return;
      end
      check($sformatf("txd[%0d]", i), 32'(txd_s), 32'(exp_bit(i, n, w, aw)));
      check("frame_busy", 32'(busy_s), 32'd1);
      check("frame_done", 32'(done_s), 32'd0);
      if (i == mid_start) begin
        set_start(1'b1);
        num_words = 32'd5;
      end else if (i == mid_start + 1) begin
        set_start(1'b0);
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(done_s), 32'd1);
    check("done_busy", 32'(busy_s), 32'd0);
    check("done_txd", 32'(txd_s), 32'd1);
    check("oe_count", 32'(addr_q.size()), 32'(n));
    foreach (addr_q[j]) check($sformatf("oe_addr[%0d]", j), addr_q[j], 32'(j % (1 << aw)));
    @(negedge clk);
    check("done_clear", 32'(done_s), 32'd0);
  endtask

  initial begin
    rst_async = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    num_words = '0;
    sel       = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_txd_a", 32'(txd_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_oe_a", 32'(oe_a), 32'd0);
    check("rst_addr_a", 32'(addr_a), 32'd0);
    check("rst_txd_b", 32'(txd_b), 32'd1);
    check("rst_addr_b", 32'(addr_b), 32'd0);
    rst_async = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(0, 4, 14, -1, -1);
    mem[0] = 32'h12345678;
    mem[1] = 32'hDEADBEEF;
    run_frame(2, 4, 14, -1, -1);
    run_frame(3, 4, 14, 100, -1);
    // data bit 3 of payload byte 2 (frame byte 6), mid-bit
    run_frame(2, 4, 14, -1, 6 * 40 + 4 * 4 + 1);
    run_frame(2, 4, 14, -1, -1);
    repeat (4) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      run_frame(int'($urandom_range(0, 5)), 4, 14, -1, -1);
    end

    sel = 1'b1;
    run_frame(6, 2, 2, -1, -1);
    run_frame(3, 2, 2, -1, -1);
    run_frame(3, 2, 2, -1, -1);
    repeat (3) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      run_frame(int'($urandom_range(0, 7)), 2, 2, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/image_uart_sender.md
IMAGE_UART_SENDER -- requirements
Module: image_uart_sender

Interface
REQ-001 Parameter SERIAL_WCNT, default 100, clocks per UART bit; legal range 2..65535.
REQ-002 Parameter ADDR_W, default 14, word-address width of the source memory port.
REQ-003 clk  input  1  clock; reset rst_async, asynchronous, active-high; clock clk.
REQ-004 rst_async  input  1  asynchronous active-high reset.
REQ-005 start  input  1  single-cycle request to stream an image; accepted only when busy=0.
REQ-006 num_words  input  32  word count, sampled when start is accepted; only bits [29:0] are used.
REQ-007 mem_addr  output  ADDR_W  word address into the source memory.
REQ-008 mem_oe  output  1  read strobe; mem_rdata is valid exactly 1 cycle after mem_oe=1.
REQ-009 mem_rdata  input  32  read data.
REQ-010 txd  output  1  serial line, registered, idle high.
REQ-011 busy  output  1  high from the cycle after start is accepted until the cycle done is pulsed.
REQ-012 done  output  1  one-cycle pulse after the last stop bit completes.

Function
REQ-013 Line format: 8N1, one start bit (0), 8 data bits LSB first, one stop bit (1); each bit lasts exactly SERIAL_WCNT cycles.
REQ-014 Frame: a 4-byte header equal to byte count = num_words[29:0]*4 (32-bit, little-endian), then the words at addresses 0..num_words-1, each little-endian (byte 0 = bits [7:0]).
REQ-015 The frame matches the program-loader receive format: header length first, then payload.
REQ-016 States: IDLE, HDR (header bytes 0..3), DATA (word bytes 0..3), FIN (assert done, return to IDLE).
REQ-017 IDLE -> HDR on start; HDR -> DATA after header byte 3 if num_words!=0, otherwise HDR -> FIN; DATA -> FIN after byte 3 of word num_words-1; FIN -> IDLE after 1 cycle.
REQ-018 Start accepted at edge N: txd drives the first start bit from edge N+1 onward.
REQ-019 Bytes are back-to-back: the next start bit immediately follows the previous stop bit, with zero idle cycles, for the whole frame.
REQ-020 Prefetch: the word read is issued (mem_oe=1 for exactly one cycle) during byte 3 of the preceding byte group, so it never stalls the line; one read per word, in ascending address order.
REQ-021 mem_addr wraps modulo 2^ADDR_W when num_words > 2^ADDR_W.
REQ-022 start asserted while busy=1 is ignored; num_words changes while busy have no effect.
REQ-023 done is asserted the cycle after the final stop bit ends; busy falls in the same cycle; start may be accepted in the cycle following done.
REQ-024 The word counter and byte counter are each at least 30 and 2 bits wide; no overflow is possible for any legal num_words.

Reset
REQ-025 rst_async forces immediately: state IDLE, txd=1, busy=0, done=0, mem_oe=0, mem_addr=0, and all counters 0.
REQ-026 Reset during a frame abandons it with no partial stop bit and no done pulse; release resumes in IDLE.
REQ-027 rst_async is released synchronously: asserted asynchronously, deasserted through a 2-flop synchronizer on clk.

Structure
REQ-028 The state encoding, the header byte count (4) and the bytes-per-word value (4) are placed in a shared package.
REQ-029 Serialization is in one sub-module, uart_byte_tx, which has the following ports:
- load: loads a byte.
- data: the 8-bit byte to send.
- ready: high in the last cycle of the stop bit, allowing a zero-gap reload.
- txd: the serial output.
REQ-030 The sequencer FSM, counters and memory port live in image_uart_sender; target size is 150-300 lines total.

Verification
REQ-031 SERIAL_WCNT=4, num_words=0, start -> txd carries header 00 00 00 00 (40 bit-times = 160 cycles), then done at cycle 161 after acceptance; mem_oe never asserted.
REQ-032 SERIAL_WCNT=4, num_words=2, mem[0]=0x12345678, mem[1]=0xDEADBEEF -> decoded bytes 08 00 00 00 78 56 34 12 EF BE AD DE, zero inter-byte gaps, exactly 2 mem_oe pulses (addr 0 then 1).
REQ-033 start pulsed again mid-frame with num_words=5 -> ignored; the frame content and length are unchanged.
REQ-034 rst_async asserted during the data bit 3 of payload byte 2 -> txd=1 in the same cycle, busy=0, no done; a new start after release sends a full correct frame.
REQ-035 ADDR_W=2, num_words=6 -> mem_addr sequence 0,1,2,3,0,1; header bytes 18 00 00 00.
REQ-036 SERIAL_WCNT=2 (minimum), num_words=3 -> every bit is 2 cycles wide, back-to-back, and the payload is correct; a second start the cycle after done produces an identical frame.
